// File: rtl/resp_checker.sv
// Response checker: expected words are queued in a small FIFO, observed words are
// popped and compared in order; counts vectors/errors and reports done/pass.
module resp_checker #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_tests,
  input  logic                  exp_valid,
  input  logic [DATA_WIDTH-1:0] exp_data,
  output logic                  exp_ready,
  input  logic                  obs_valid,
  input  logic [DATA_WIDTH-1:0] obs_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  mismatch,
  output logic                  underflow,
  output logic [CNT_WIDTH-1:0]  vec_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  first_err_idx
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]  num_q;

  logic fifo_empty, fifo_full;
  logic push, obs_acc, pop, uf_hit, err_hit, clear;
  logic [CNT_WIDTH-1:0] vec_inc, err_inc;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign exp_ready = !fifo_full && (state != DONE);
  assign push      = exp_valid && exp_ready;
  assign obs_acc   = obs_valid && (state == RUN);
  assign pop       = obs_acc && !fifo_empty;
  assign uf_hit    = obs_acc && fifo_empty;
  assign err_hit   = uf_hit || (pop && (obs_data != mem[rd_ptr[AW-1:0]]));
  assign clear     = (state == DONE) && start;

  assign vec_inc = (vec_count == '1) ? vec_count : vec_count + CNT_WIDTH'(1);
  assign err_inc = (err_count == '1) ? err_count : err_count + CNT_WIDTH'(1);

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0) && !underflow;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = (num_tests == '0) ? DONE : RUN;
      RUN:  if (obs_acc && (vec_inc == num_q)) state_next = DONE;
      DONE: if (start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the storage array is not reset; pointers alone define which entries are
  // valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= exp_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      num_q         <= '0;
      vec_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      underflow     <= 1'b0;
      mismatch      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if ((state == IDLE) && start) num_q <= num_tests;
      mismatch <= err_hit;
      if (uf_hit) underflow <= 1'b1;
      if (obs_acc) vec_count <= vec_inc;
      if (err_hit) begin
        err_count <= err_inc;
        if (err_count == '0) first_err_idx <= vec_count;
      end
    end
  end

endmodule

// File: tb/tb_resp_checker.sv
// Bench for resp_checker: table of whole-run cases plus hand sequences, with a
// queue-based scoreboard of expected words and independent per-case result constants.
module tb_resp_checker;

  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_tests = '0;
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_ready;
  logic          obs_valid = 1'b0;
  logic [DW-1:0] obs_data = '0;
  logic          busy, done, pass, mismatch, underflow;
  logic [CW-1:0] vec_count, err_count, first_err_idx;

  resp_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_tests(num_tests),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .obs_valid(obs_valid), .obs_data(obs_data),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch), .underflow(underflow),
    .vec_count(vec_count), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Behavioural model and scoreboard of expected words.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t     m_state = M_IDLE;
  logic [63:0] sb[$];
  int          m_num = 0, m_vec = 0, m_err = 0, m_first = 0;
  logic        m_uf = 1'b0;

  task automatic model_clear();
    m_state = M_IDLE; m_vec = 0; m_err = 0; m_first = 0; m_uf = 1'b0; m_num = 0;
    sb.delete();
  endtask

  task automatic check_outputs(input logic exp_mis);
    check("mismatch", mismatch, exp_mis);
    check("vec_count", vec_count, m_vec);
    check("err_count", err_count, m_err);
    check("busy", busy, m_state == M_RUN);
    check("done", done, m_state == M_DONE);
    check("underflow", underflow, m_uf);
    check("pass", pass, (m_state == M_DONE) && (m_err == 0) && !m_uf);
    if (m_err != 0) check("first_err_idx", first_err_idx, m_first);
  endtask

  // One clock cycle of stimulus; returns whether the push was accepted.
  task automatic cycle(input logic do_push, input logic [63:0] pdata,
                       input logic do_obs, input logic [63:0] odata,
                       input logic do_start, input int nt, output logic accepted);
    logic        rdy, acc, e;
    logic [63:0] h;
    int          old_vec;
    rdy = (m_state != M_DONE) && (sb.size() < DEPTH);
    check("exp_ready", exp_ready, rdy);
    exp_valid = do_push; exp_data = pdata;
    obs_valid = do_obs;  obs_data = odata;
    start = do_start;    num_tests = nt;
    @(posedge clk);
    e = 1'b0;
    acc = do_obs && (m_state == M_RUN);
    old_vec = m_vec;
    if (acc) begin
      if (sb.size() == 0) begin
        e = 1'b1; m_uf = 1'b1;
      end else begin
        h = sb.pop_front();
        e = (h != odata);
      end
      m_vec++;
      if (e) begin
        if (m_err == 0) m_first = old_vec;
        m_err++;
      end
    end
    accepted = do_push && rdy;
    if (accepted) sb.push_back(pdata);
    case (m_state)
      M_IDLE: if (do_start) begin m_num = nt; m_state = (nt == 0) ? M_DONE : M_RUN; end
      M_RUN:  if (acc && (m_vec == m_num)) m_state = M_DONE;
      default: if (do_start) model_clear();
    endcase
    #1;
    exp_valid = 1'b0; obs_valid = 1'b0; start = 1'b0;
    check_outputs(e);
  endtask

  typedef struct packed {
    logic [31:0] n_pre;
    logic [31:0] n_obs;
    logic [31:0] bad_idx;
    logic [63:0] bad_val;
    logic [31:0] num;
    logic        exp_pass;
    logic [31:0] exp_err;
    logic [31:0] exp_first;
    logic        exp_uf;
  } case_t;

  localparam int NCASES = 7;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;
  case_t       cases [NCASES];
  logic [63:0] base  [10];

  initial begin
    logic acc;
    int   pushed;
    logic [63:0] v;

    base = '{64'd0, 64'd11, 64'd20, 64'd25, 64'd30, 64'd35, 64'd40, 64'd50, 64'd60, 64'd63};
    //          n_pre n_obs bad_idx bad_val num pass err first uf
    cases[0] = '{32'd10, 32'd10, NONE,  64'd0,  32'd10, 1'b1, 32'd0, 32'd0, 1'b0};
    cases[1] = '{32'd10, 32'd10, 32'd3, 64'd26, 32'd10, 1'b0, 32'd1, 32'd3, 1'b0};
    cases[2] = '{32'd10, 32'd10, 32'd9, 64'd64, 32'd10, 1'b0, 32'd1, 32'd9, 1'b0};
    cases[3] = '{32'd0,  32'd1,  32'd0, 64'd5,  32'd1,  1'b0, 32'd1, 32'd0, 1'b1};
    cases[4] = '{32'd0,  32'd0,  NONE,  64'd0,  32'd0,  1'b1, 32'd0, 32'd0, 1'b0};
    cases[5] = '{32'd10, 32'd4,  NONE,  64'd0,  32'd4,  1'b1, 32'd0, 32'd0, 1'b0};
    cases[6] = '{32'd3,  32'd3,  32'd0, 64'd1,  32'd3,  1'b0, 32'd1, 32'd0, 1'b0};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    check_outputs(1'b0);
    check("reset_exp_ready", exp_ready, 1'b1);

    for (int c = 0; c < NCASES; c++) begin
      pushed = 0;
      for (int k = 0; k < int'(cases[c].n_pre) && k < DEPTH; k++) begin
        cycle(1'b1, base[k], 1'b0, '0, 1'b0, 0, acc);
        if (acc) pushed++;
      end
      cycle(1'b0, '0, 1'b0, '0, 1'b1, int'(cases[c].num), acc);
      for (int i = 0; i < int'(cases[c].n_obs); i++) begin
        v = (i == int'(cases[c].bad_idx)) ? cases[c].bad_val : base[i];
        if (pushed < int'(cases[c].n_pre)) begin
          cycle(1'b1, base[pushed], 1'b1, v, 1'b0, 0, acc);
          if (acc) pushed++;
        end else begin
          cycle(1'b0, '0, 1'b1, v, 1'b0, 0, acc);
        end
      end
      check("case_done", done, 1'b1);
      check("case_pass", pass, cases[c].exp_pass);
      check("case_vec", vec_count, cases[c].num);
      check("case_err", err_count, cases[c].exp_err);
      if (cases[c].exp_err != 0) check("case_first", first_err_idx, cases[c].exp_first);
      check("case_uf", underflow, cases[c].exp_uf);
      cycle(1'b0, '0, 1'b1, 64'd7, 1'b0, 0, acc);
      check("done_hold", done, 1'b1);
      check("done_no_ready", exp_ready, 1'b0);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, 0, acc);
      check("clear_vec", vec_count, 0);
      check("clear_done", done, 1'b0);
    end

    // FIFO full: ninth push is held until a pop frees an entry.
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, 64'd100 + 64'(k), 1'b0, '0, 1'b0, 0, acc);
    check("t3_full", exp_ready, 1'b0);
    cycle(1'b1, 64'd108, 1'b0, '0, 1'b1, 9, acc);
    check("t3_held_start", acc, 1'b0);
    cycle(1'b1, 64'd108, 1'b1, 64'd100, 1'b0, 0, acc);
    check("t3_held_pop", acc, 1'b0);
    check("t3_ready_after_pop", exp_ready, 1'b1);
    cycle(1'b1, 64'd108, 1'b1, 64'd101, 1'b0, 0, acc);
    check("t3_accepted", acc, 1'b1);
    for (int k = 2; k < 9; k++) cycle(1'b0, '0, 1'b1, 64'd100 + 64'(k), 1'b0, 0, acc);
    check("t3_pass", pass, 1'b1);
    check("t3_vec", vec_count, 9);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 0, acc);

    // No bypass: obs on empty FIFO is underflow even with a same-cycle push.
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1, acc);
    cycle(1'b1, 64'd7, 1'b1, 64'd7, 1'b0, 0, acc);
    check("nobypass_uf", underflow, 1'b1);
    check("nobypass_pass", pass, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 0, acc);

    // Reset mid-run after 5 of 10 observations.
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, base[k], 1'b0, '0, 1'b0, 0, acc);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 10, acc);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, base[i], 1'b0, 0, acc);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    check_outputs(1'b0);
    check("t6_vec", vec_count, 0);
    check("t6_done", done, 1'b0);
    check("t6_busy", busy, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1, acc);
    cycle(1'b0, '0, 1'b1, base[5], 1'b0, 0, acc);
    check("t6_fifo_empty", underflow, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
